aximm_burst_sequencer: RTL and testbench
========================================

// Module: aximm_burst_sequencer
// PURPOSE
//  AXI4-MM leader-side traffic sequencer for the follower memory datapath. On i_start it issues one
//  INCR write burst of a generated pattern, waits for B, issues a read burst to the same address,
//  compares every R beat against the pattern and reports pass/fail. Sits on user_* leader ports.
// PARAMETERS
//  DWIDTH      128  AXI data width; multiple of 32
//  ADDRWIDTH   32   AXI address width
//  TIMEOUT_CYC 1024 watchdog limit in cycles; used only with AXIMM_SEQ_TIMEOUT_EN
// PORTS
//  clk            in   1          clock
//  rst_n          in   1          synchronous active-low reset
//  i_start        in   1          one-cycle pulse; starts a sequence when idle
//  i_base_addr    in   ADDRWIDTH  burst start address (awaddr = araddr)
//  i_num_beats    in   8          beats per burst; 0 means 256
//  i_seed         in   16         pattern seed
//  o_busy         out  1          sequence in progress
//  o_done         out  1          one-cycle pulse at end of sequence
//  o_pass         out  1          valid while o_done high: 1 = err_cnt==0 and no timeout
//  o_err_cnt      out  8          data/resp/last errors in last sequence; saturates at 255
//  o_timeout      out  1          watchdog fired in last sequence (0 without macro)
//  user_aw{id,size,len,burst,addr,valid} out 4/3/8/2/ADDRWIDTH/1; user_awready in 1
//  user_w{id,data,strb,last,valid}       out 4/DWIDTH/16/1/1;     user_wready  in 1
//  user_b{id,resp,valid} in 4/2/1;       user_bready out 1
//  user_ar{id,size,len,burst,addr,valid} out 4/3/8/2/ADDRWIDTH/1; user_arready in 1
//  user_r{id,data,last,resp,valid} in 4/DWIDTH/1/2/1;            user_rready  out 1
// BEHAVIOUR
//  Reset: FSM=IDLE; all valid/ready outputs, o_busy, o_done, o_pass, o_timeout = 0; o_err_cnt = 0;
//   AXI payload outputs 0. Reset mid-burst drops all valids on the next edge; no completion.
//  FSM: IDLE -> AW -> W -> B -> AR -> R -> DONE -> IDLE.
//   IDLE: i_start high -> latch addr/beats/seed, clear err_cnt/timeout, o_busy=1; AW next cycle.
//   AW: awvalid=1 held until awready; awid=0, awsize=log2(DWIDTH/8), awburst=2'b01 INCR,
//       awlen=i_num_beats-1 (8-bit wrap: 0 -> 255).
//   W: wvalid=1; beat index k advances on each wvalid&wready; wlast=1 on k==N-1; wstrb=all ones;
//       leave W on handshake of last beat. Data/last stable while wvalid && !wready.
//   B: bready=1; on bvalid: bresp!=2'b00 -> err+1; go AR.
//   AR: arvalid=1 held until arready; same id/size/burst/len/addr as AW.
//   R: rready=1; per rvalid beat k: rdata!=pattern(k) -> err+1; rresp!=0 -> err+1;
//       rlast at k!=N-1 -> err+1; beat k==N-1 without rlast -> err+1. Phase ends on rlast beat.
//       Beats beyond N (k>=N) are each counted as errors until rlast.
//   DONE: o_done=1 and o_pass valid for exactly one cycle, o_busy=0 on the following cycle; IDLE.
//  Pattern: 32-bit word w(k) = {i_seed, 8'h00, k[7:0]}; pattern(k) = w(k) replicated DWIDTH/32.
//  Handshake rules: valid never depends combinationally on ready; valid never retracted before ready.
//  Simultaneous events: i_start while o_busy ignored; two errors on one beat add 2 (saturating).
//  Latency: i_start -> awvalid 1 cycle; last R handshake -> o_done 1 cycle.
// CONFIGURATION
//  AXIMM_SEQ_TIMEOUT_EN defined: counter resets on every AXI handshake and on state change;
//   reaching TIMEOUT_CYC in AW/W/B/AR/R -> drop all valid/ready, o_timeout=1, go DONE, o_pass=0.
//  Not defined: no counter; o_timeout tied 0; FSM waits indefinitely for handshakes.
// STRUCTURE
//  Package aximm_seq_pkg: FSM state enum, RESP_OKAY=2'b00, BURST_INCR=2'b01, pattern function.
//  Sub-module aximm_seq_watchdog (counter + fire flag), instantiated only under the macro.
// TESTING
//  1) base=0x10, N=4, seed=0x1234, follower echoes -> awlen=3, wlast on beat 3, o_pass=1, err=0.
//  2) N=1 -> single beat with wlast=1, awlen=0, one R beat with rlast, o_pass=1.
//  3) corrupt R beat 2 bit 0, N=8 -> o_err_cnt=1, o_pass=0, sequence still completes.
//  4) awready held low 5 cycles, wready toggling every cycle -> awaddr/wdata stable, no lost beats.
//  5) bresp=2'b10, rresp OK -> o_err_cnt=1; rlast on beat 2 of N=4 -> +1 error, R ends there.
//  6) rst_n low during W beat 3 of N=8 -> next cycle all valids 0, FSM IDLE, no o_done;
//     with AXIMM_SEQ_TIMEOUT_EN and bvalid never asserted -> o_timeout=1 after TIMEOUT_CYC.

Source files
------------

// File: rtl/aximm_seq_pkg.sv
// Shared types and helpers for the AXI4-MM burst sequencer: FSM states, AXI encodings, test pattern.
package aximm_seq_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_AW,
    ST_W,
    ST_B,
    ST_AR,
    ST_R,
    ST_DONE
  } seq_state_e;

  localparam logic [1:0] RESP_OKAY  = 2'b00;
  localparam logic [1:0] BURST_INCR = 2'b01;

  // One 32-bit lane of the beat pattern; the top replicates it across the data bus.
  function automatic logic [31:0] pattern_word(input logic [15:0] seed, input logic [7:0] k);
    return {seed, 8'h00, k};
  endfunction

  function automatic logic [7:0] sat_add(input logic [7:0] cnt, input logic [1:0] inc);
    logic [8:0] sum;
    sum = {1'b0, cnt} + {7'd0, inc};
    return sum[8] ? 8'hFF : sum[7:0];
  endfunction

endpackage

// File: rtl/aximm_seq_watchdog.sv
// Stall watchdog for the burst sequencer; counts idle cycles while a phase is active.
module aximm_seq_watchdog #(
  parameter int TIMEOUT_CYC = 1024
) (
  input  logic clk,
  input  logic rst_n,
  input  logic active,
  input  logic clear,
  output logic fire
);

  localparam int CW = $clog2(TIMEOUT_CYC + 1);

  logic [CW-1:0] cnt;

  always_ff @(posedge clk) begin
    if (!rst_n || !active || clear) begin
      cnt <= '0;
    end else if (!fire) begin
      cnt <= cnt + CW'(1);
    end
  end

  assign fire = active && !clear && (cnt == CW'(TIMEOUT_CYC - 1));

endmodule

// File: rtl/aximm_burst_sequencer.sv
// AXI4-MM write-then-readback burst sequencer with pattern check.
// Optional stall watchdog enabled by defining AXIMM_SEQ_TIMEOUT_EN.
module aximm_burst_sequencer
  import aximm_seq_pkg::*;
#(
  parameter int DWIDTH      = 128,
  parameter int ADDRWIDTH   = 32,
  parameter int TIMEOUT_CYC = 1024
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 i_start,
  input  logic [ADDRWIDTH-1:0] i_base_addr,
  input  logic [7:0]           i_num_beats,
  input  logic [15:0]          i_seed,
  output logic                 o_busy,
  output logic                 o_done,
  output logic                 o_pass,
  output logic [7:0]           o_err_cnt,
  output logic                 o_timeout,
  output logic [3:0]           user_awid,
  output logic [2:0]           user_awsize,
  output logic [7:0]           user_awlen,
  output logic [1:0]           user_awburst,
  output logic [ADDRWIDTH-1:0] user_awaddr,
  output logic                 user_awvalid,
  input  logic                 user_awready,
  output logic [3:0]           user_wid,
  output logic [DWIDTH-1:0]    user_wdata,
  output logic [15:0]          user_wstrb,
  output logic                 user_wlast,
  output logic                 user_wvalid,
  input  logic                 user_wready,
  input  logic [3:0]           user_bid,
  input  logic [1:0]           user_bresp,
  input  logic                 user_bvalid,
  output logic                 user_bready,
  output logic [3:0]           user_arid,
  output logic [2:0]           user_arsize,
  output logic [7:0]           user_arlen,
  output logic [1:0]           user_arburst,
  output logic [ADDRWIDTH-1:0] user_araddr,
  output logic                 user_arvalid,
  input  logic                 user_arready,
  input  logic [3:0]           user_rid,
  input  logic [DWIDTH-1:0]    user_rdata,
  input  logic                 user_rlast,
  input  logic [1:0]           user_rresp,
  input  logic                 user_rvalid,
  output logic                 user_rready
);

  localparam logic [2:0] AXSIZE = 3'($clog2(DWIDTH / 8));

  seq_state_e state, state_nxt;
  logic [ADDRWIDTH-1:0] addr_q;
  logic [7:0]  len_q, beat_q, err_q;
  logic [15:0] seed_q;
  logic        over_q, timeout_q;
  logic        aw_hs, w_hs, b_hs, ar_hs, r_hs, fire;
  logic        last_beat;
  logic [1:0]  r_err;
  logic [DWIDTH-1:0] pattern;
  logic        unused_ids;

  assign unused_ids = ^{user_bid, user_rid};

  assign aw_hs     = (state == ST_AW) && user_awready;
  assign w_hs      = (state == ST_W)  && user_wready;
  assign b_hs      = (state == ST_B)  && user_bvalid;
  assign ar_hs     = (state == ST_AR) && user_arready;
  assign r_hs      = (state == ST_R)  && user_rvalid;
  assign last_beat = (beat_q == len_q);
  assign pattern   = {(DWIDTH / 32){pattern_word(seed_q, beat_q)}};

`ifdef AXIMM_SEQ_TIMEOUT_EN
  seq_state_e prev_state;
  logic       wd_active;

  always_ff @(posedge clk) begin
    if (!rst_n) prev_state <= ST_IDLE;
    else        prev_state <= state;
  end

  assign wd_active = (state != ST_IDLE) && (state != ST_DONE);

  aximm_seq_watchdog #(.TIMEOUT_CYC(TIMEOUT_CYC)) u_watchdog (
    .clk    (clk),
    .rst_n  (rst_n),
    .active (wd_active),
    .clear  (aw_hs || w_hs || b_hs || ar_hs || r_hs || (state != prev_state)),
    .fire   (fire)
  );
`else
  // No watchdog: the FSM waits indefinitely for every handshake.
  assign fire = (TIMEOUT_CYC < 0);
`endif

  // Beats past the advertised length count once each; otherwise data, resp and last are checked.
  always_comb begin
    r_err = 2'd0;
    if (over_q) begin
      r_err = 2'd1;
    end else begin
      if (user_rdata != pattern)     r_err = r_err + 2'd1;
      if (user_rresp != RESP_OKAY)   r_err = r_err + 2'd1;
      if (user_rlast != last_beat)   r_err = r_err + 2'd1;
    end
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      ST_IDLE: if (i_start)                state_nxt = ST_AW;
      ST_AW:   if (aw_hs)                  state_nxt = ST_W;
      ST_W:    if (w_hs && last_beat)      state_nxt = ST_B;
      ST_B:    if (b_hs)                   state_nxt = ST_AR;
      ST_AR:   if (ar_hs)                  state_nxt = ST_R;
      ST_R:    if (r_hs && user_rlast)     state_nxt = ST_DONE;
      ST_DONE:                             state_nxt = ST_IDLE;
      default:                             state_nxt = ST_IDLE;
    endcase
    if (fire) state_nxt = ST_DONE;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= ST_IDLE;
      addr_q    <= '0;
      len_q     <= '0;
      seed_q    <= '0;
      beat_q    <= '0;
      over_q    <= 1'b0;
      err_q     <= '0;
      timeout_q <= 1'b0;
    end else begin
      state <= state_nxt;
      if ((state == ST_IDLE) && i_start) begin
        addr_q    <= i_base_addr;
        len_q     <= i_num_beats - 8'd1;
        seed_q    <= i_seed;
        beat_q    <= '0;
        over_q    <= 1'b0;
        err_q     <= '0;
        timeout_q <= 1'b0;
      end
      if (w_hs) beat_q <= last_beat ? 8'd0 : beat_q + 8'd1;
      if (b_hs && (user_bresp != RESP_OKAY)) err_q <= sat_add(err_q, 2'd1);
      if (r_hs) begin
        err_q <= sat_add(err_q, r_err);
        if (!over_q) begin
          if (last_beat) over_q <= 1'b1;
          else           beat_q <= beat_q + 8'd1;
        end
      end
      if (fire) timeout_q <= 1'b1;
    end
  end

  // Payloads are zero outside their own phase so idle/reset buses stay quiet.
  assign user_awid    = 4'd0;
  assign user_awvalid = (state == ST_AW);
  assign user_awaddr  = user_awvalid ? addr_q : '0;
  assign user_awlen   = user_awvalid ? len_q : 8'd0;
  assign user_awsize  = user_awvalid ? AXSIZE : 3'd0;
  assign user_awburst = user_awvalid ? BURST_INCR : 2'b00;

  assign user_wid     = 4'd0;
  assign user_wvalid  = (state == ST_W);
  assign user_wdata   = user_wvalid ? pattern : '0;
  assign user_wstrb   = user_wvalid ? 16'hFFFF : 16'h0000;
  assign user_wlast   = user_wvalid && last_beat;

  assign user_bready  = (state == ST_B);

  assign user_arid    = 4'd0;
  assign user_arvalid = (state == ST_AR);
  assign user_araddr  = user_arvalid ? addr_q : '0;
  assign user_arlen   = user_arvalid ? len_q : 8'd0;
  assign user_arsize  = user_arvalid ? AXSIZE : 3'd0;
  assign user_arburst = user_arvalid ? BURST_INCR : 2'b00;

  assign user_rready  = (state == ST_R);

  assign o_busy    = (state != ST_IDLE);
  assign o_done    = (state == ST_DONE);
  assign o_pass    = o_done && (err_q == 8'd0) && !timeout_q;
  assign o_err_cnt = err_q;
  assign o_timeout = timeout_q;

endmodule

// File: tb/tb_aximm_burst_sequencer.sv
// Directed bench for aximm_burst_sequencer acting as a scripted AXI follower.
// Adds a watchdog scenario when AXIMM_SEQ_TIMEOUT_EN is defined.
module tb_aximm_burst_sequencer;

  localparam int DW = 128;
  localparam int AW = 32;
  localparam int TO = 64;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          i_start;
  logic [AW-1:0] i_base_addr;
  logic [7:0]    i_num_beats;
  logic [15:0]   i_seed;
  logic          o_busy, o_done, o_pass, o_timeout;
  logic [7:0]    o_err_cnt;
  logic [3:0]    user_awid, user_wid, user_bid, user_arid, user_rid;
  logic [2:0]    user_awsize, user_arsize;
  logic [7:0]    user_awlen, user_arlen;
  logic [1:0]    user_awburst, user_arburst, user_bresp, user_rresp;
  logic [AW-1:0] user_awaddr, user_araddr;
  logic          user_awvalid, user_awready, user_wlast, user_wvalid, user_wready;
  logic          user_bvalid, user_bready, user_arvalid, user_arready;
  logic          user_rlast, user_rvalid, user_rready;
  logic [DW-1:0] user_wdata, user_rdata;
  logic [15:0]   user_wstrb;

  int nVec = 0;
  int nMis = 0;

  always #5 clk = ~clk;

  aximm_burst_sequencer #(.DWIDTH(DW), .ADDRWIDTH(AW), .TIMEOUT_CYC(TO)) dut (
    .clk(clk), .rst_n(rst_n), .i_start(i_start), .i_base_addr(i_base_addr),
    .i_num_beats(i_num_beats), .i_seed(i_seed), .o_busy(o_busy), .o_done(o_done),
    .o_pass(o_pass), .o_err_cnt(o_err_cnt), .o_timeout(o_timeout),
    .user_awid(user_awid), .user_awsize(user_awsize), .user_awlen(user_awlen),
    .user_awburst(user_awburst), .user_awaddr(user_awaddr), .user_awvalid(user_awvalid),
    .user_awready(user_awready), .user_wid(user_wid), .user_wdata(user_wdata),
    .user_wstrb(user_wstrb), .user_wlast(user_wlast), .user_wvalid(user_wvalid),
    .user_wready(user_wready), .user_bid(user_bid), .user_bresp(user_bresp),
    .user_bvalid(user_bvalid), .user_bready(user_bready), .user_arid(user_arid),
    .user_arsize(user_arsize), .user_arlen(user_arlen), .user_arburst(user_arburst),
    .user_araddr(user_araddr), .user_arvalid(user_arvalid), .user_arready(user_arready),
    .user_rid(user_rid), .user_rdata(user_rdata), .user_rlast(user_rlast),
    .user_rresp(user_rresp), .user_rvalid(user_rvalid), .user_rready(user_rready)
  );

  typedef struct {
    logic [31:0] base;
    logic [7:0]  nbeats;
    logic [15:0] seed;
    logic [1:0]  bresp;
    int          corrupt_beat;
    int          bad_resp_beat;
    int          early_last;
    int          aw_delay;
    bit          w_toggle;
    logic [7:0]  exp_awlen;
    logic [7:0]  exp_err;
    logic        exp_pass;
  } vec_t;

  vec_t vecs[8];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string name, input logic [127:0] act, input logic [127:0] exp);
    nVec++;
    if (act !== exp) begin
      nMis++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [127:0] patternOf(input logic [15:0] seed, input int k);
    logic [7:0] kb;
    kb = k[7:0];
    return {4{seed, 8'h00, kb}};
  endfunction

  task automatic applyStimulus(input vec_t v);
    int n, lastR, cyc, k;
    n     = (v.nbeats == 8'd0) ? 256 : int'(v.nbeats);
    lastR = (v.early_last >= 0) ? v.early_last : n - 1;
    i_base_addr = v.base;
    i_num_beats = v.nbeats;
    i_seed      = v.seed;
    i_start     = 1'b1;
    tick();
    i_start = 1'b0;
    checkOutput("awvalid_latency", user_awvalid, 1'b1);
    checkOutput("busy", o_busy, 1'b1);
    for (int d = 0; d < v.aw_delay; d++) begin
      tick();
      checkOutput("awvalid_hold", user_awvalid, 1'b1);
      checkOutput("awaddr_stable", user_awaddr, v.base);
    end
    checkOutput("awaddr", user_awaddr, v.base);
    checkOutput("awlen", user_awlen, v.exp_awlen);
    checkOutput("awsize", user_awsize, 3'd4);
    checkOutput("awburst", user_awburst, 2'b01);
    user_awready = 1'b1;
    tick();
    user_awready = 1'b0;

    k = 0;
    cyc = 0;
    while (k < n && cyc < 2000) begin
      user_wready = v.w_toggle ? cyc[0] : 1'b1;
      checkOutput("wvalid", user_wvalid, 1'b1);
      checkOutput("wdata", user_wdata, patternOf(v.seed, k));
      if (user_wready) begin
        checkOutput("wlast", user_wlast, (k == n - 1));
        checkOutput("wstrb", user_wstrb, 16'hFFFF);
      end
      tick();
      if (user_wready) k++;
      cyc++;
    end
    user_wready = 1'b0;
    checkOutput("w_beats", k, n);

    checkOutput("bready", user_bready, 1'b1);
    user_bvalid = 1'b1;
    user_bresp  = v.bresp;
    tick();
    user_bvalid = 1'b0;
    user_bresp  = 2'b00;

    checkOutput("arvalid", user_arvalid, 1'b1);
    checkOutput("araddr", user_araddr, v.base);
    checkOutput("arlen", user_arlen, v.exp_awlen);
    user_arready = 1'b1;
    tick();
    user_arready = 1'b0;

    for (int r = 0; r <= lastR; r++) begin
      checkOutput("rready", user_rready, 1'b1);
      user_rvalid = 1'b1;
      user_rdata  = patternOf(v.seed, r) ^ ((r == v.corrupt_beat) ? 128'd1 : 128'd0);
      user_rresp  = (r == v.bad_resp_beat) ? 2'b10 : 2'b00;
      user_rlast  = (r == lastR);
      tick();
    end
    user_rvalid = 1'b0;
    user_rlast  = 1'b0;
    user_rresp  = 2'b00;

    checkOutput("done", o_done, 1'b1);
    checkOutput("pass", o_pass, v.exp_pass);
    checkOutput("err_cnt", o_err_cnt, v.exp_err);
    checkOutput("timeout_flag", o_timeout, 1'b0);
    tick();
    checkOutput("done_pulse", o_done, 1'b0);
    checkOutput("busy_after", o_busy, 1'b0);
  endtask

  initial begin
    rst_n = 1'b0; i_start = 1'b0; i_base_addr = '0; i_num_beats = '0; i_seed = '0;
    user_awready = 1'b0; user_wready = 1'b0; user_bid = '0; user_bresp = '0;
    user_bvalid = 1'b0; user_arready = 1'b0; user_rid = '0; user_rdata = '0;
    user_rlast = 1'b0; user_rresp = '0; user_rvalid = 1'b0;

    vecs[0] = '{base:32'h10,  nbeats:8'd4, seed:16'h1234, bresp:2'b00, corrupt_beat:-1, bad_resp_beat:-1, early_last:-1, aw_delay:0, w_toggle:1'b0, exp_awlen:8'd3,   exp_err:8'd0, exp_pass:1'b1};
    vecs[1] = '{base:32'h200, nbeats:8'd1, seed:16'hBEEF, bresp:2'b00, corrupt_beat:-1, bad_resp_beat:-1, early_last:-1, aw_delay:0, w_toggle:1'b0, exp_awlen:8'd0,   exp_err:8'd0, exp_pass:1'b1};
    vecs[2] = '{base:32'h400, nbeats:8'd8, seed:16'h0F0F, bresp:2'b00, corrupt_beat:2,  bad_resp_beat:-1, early_last:-1, aw_delay:0, w_toggle:1'b0, exp_awlen:8'd7,   exp_err:8'd1, exp_pass:1'b0};
    vecs[3] = '{base:32'h1000,nbeats:8'd4, seed:16'hA5A5, bresp:2'b00, corrupt_beat:-1, bad_resp_beat:-1, early_last:-1, aw_delay:5, w_toggle:1'b1, exp_awlen:8'd3,   exp_err:8'd0, exp_pass:1'b1};
    vecs[4] = '{base:32'h80,  nbeats:8'd4, seed:16'h0001, bresp:2'b10, corrupt_beat:-1, bad_resp_beat:-1, early_last:-1, aw_delay:0, w_toggle:1'b0, exp_awlen:8'd3,   exp_err:8'd1, exp_pass:1'b0};
    vecs[5] = '{base:32'hC0,  nbeats:8'd4, seed:16'h7777, bresp:2'b00, corrupt_beat:-1, bad_resp_beat:-1, early_last:2,  aw_delay:0, w_toggle:1'b0, exp_awlen:8'd3,   exp_err:8'd1, exp_pass:1'b0};
    vecs[6] = '{base:32'h8000,nbeats:8'd0, seed:16'h00A5, bresp:2'b00, corrupt_beat:-1, bad_resp_beat:-1, early_last:-1, aw_delay:1, w_toggle:1'b0, exp_awlen:8'd255, exp_err:8'd0, exp_pass:1'b1};
    vecs[7] = '{base:32'h44,  nbeats:8'd3, seed:16'hCAFE, bresp:2'b00, corrupt_beat:1,  bad_resp_beat:1,  early_last:-1, aw_delay:2, w_toggle:1'b1, exp_awlen:8'd2,   exp_err:8'd2, exp_pass:1'b0};

    tick();
    tick();
    checkOutput("rst_awvalid", user_awvalid, 1'b0);
    checkOutput("rst_wvalid", user_wvalid, 1'b0);
    checkOutput("rst_arvalid", user_arvalid, 1'b0);
    checkOutput("rst_bready", user_bready, 1'b0);
    checkOutput("rst_rready", user_rready, 1'b0);
    checkOutput("rst_busy", o_busy, 1'b0);
    checkOutput("rst_done", o_done, 1'b0);
    checkOutput("rst_pass", o_pass, 1'b0);
    checkOutput("rst_err", o_err_cnt, 8'd0);
    checkOutput("rst_timeout", o_timeout, 1'b0);
    checkOutput("rst_awaddr", user_awaddr, 32'd0);
    checkOutput("rst_wdata", user_wdata, 128'd0);
    rst_n = 1'b1;
    tick();

    for (int i = 0; i < 8; i++) begin
      $display("[TB] vector %0d", i);
      applyStimulus(vecs[i]);
      tick();
    end

    // Start pulse during a sequence is ignored, then reset lands mid-W.
    $display("[TB] mid-burst reset");
    i_base_addr = 32'h40; i_num_beats = 8'd8; i_seed = 16'h55AA; i_start = 1'b1;
    tick();
    i_base_addr = 32'h999;
    tick();
    i_start = 1'b0;
    checkOutput("start_ignored_addr", user_awaddr, 32'h40);
    user_awready = 1'b1;
    tick();
    user_awready = 1'b0;
    user_wready = 1'b1;
    for (int b = 0; b < 3; b++) tick();
    user_wready = 1'b0;
    checkOutput("mid_wvalid", user_wvalid, 1'b1);
    checkOutput("mid_wdata", user_wdata, patternOf(16'h55AA, 3));
    rst_n = 1'b0;
    tick();
    checkOutput("rst_mid_wvalid", user_wvalid, 1'b0);
    checkOutput("rst_mid_awvalid", user_awvalid, 1'b0);
    checkOutput("rst_mid_busy", o_busy, 1'b0);
    rst_n = 1'b1;
    for (int c = 0; c < 4; c++) begin
      tick();
      checkOutput("rst_mid_no_done", o_done, 1'b0);
    end

`ifdef AXIMM_SEQ_TIMEOUT_EN
    $display("[TB] watchdog on missing B");
    i_base_addr = 32'h100; i_num_beats = 8'd1; i_seed = 16'h1111; i_start = 1'b1;
    tick();
    i_start = 1'b0;
    user_awready = 1'b1;
    tick();
    user_awready = 1'b0;
    user_wready = 1'b1;
    tick();
    user_wready = 1'b0;
    checkOutput("to_bready", user_bready, 1'b1);
    for (int c = 0; c < TO + 20 && !o_done; c++) tick();
    checkOutput("to_done", o_done, 1'b1);
    checkOutput("to_flag", o_timeout, 1'b1);
    checkOutput("to_pass", o_pass, 1'b0);
    checkOutput("to_bready_drop", user_bready, 1'b0);
    tick();
`endif

    $display("== %0d vectors applied, %0d miscompares ==", nVec, nMis);
    $finish;
  end

endmodule
